// File: rtl/seq_pkg.sv
// Shared types and default widths for the melody sequencer.
// Holds the FSM state enum and the note table entry struct.
package seq_pkg;

  localparam int DEF_DEPTH   = 32;
  localparam int DEF_PITCH_W = 5;
  localparam int DEF_DUR_W   = 13;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [DEF_PITCH_W-1:0] pitch;
    logic [DEF_DUR_W-1:0]   dur;
  } note_t;

endpackage

// File: rtl/melody_sequencer_if.sv
// Control, table-write and note-output bundle of the sequencer.
// master: drives tick/wr_*/seq_len/loop_en/start/stop; slave: drives outputs.
interface melody_sequencer_if #(
  parameter int DEPTH   = 32,
  parameter int PITCH_W = 5,
  parameter int DUR_W   = 13
) ();
  localparam int AW = $clog2(DEPTH);

  logic               tick;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [PITCH_W-1:0] wr_pitch;
  logic [DUR_W-1:0]   wr_dur;
  logic [AW:0]        seq_len;
  logic               loop_en;
  logic               start;
  logic               stop;
  logic [PITCH_W-1:0] pitch_o;
  logic               note_on;
  logic               note_start;
  logic [AW-1:0]      note_idx;
  logic               busy;
  logic               done;

  modport master (
    output tick, wr_en, wr_addr, wr_pitch, wr_dur,
    output seq_len, loop_en, start, stop,
    input  pitch_o, note_on, note_start, note_idx, busy, done
  );

  modport slave (
    input  tick, wr_en, wr_addr, wr_pitch, wr_dur,
    input  seq_len, loop_en, start, stop,
    output pitch_o, note_on, note_start, note_idx, busy, done
  );
endinterface

// File: rtl/seq_note_ram.sv
// DEPTH x {pitch,dur} register file: sync write, async read.
// Ports: clk, we/wr_addr/wr_pitch/wr_dur, rd_addr -> rd_pitch/rd_dur.
module seq_note_ram #(
  parameter int DEPTH   = 32,
  parameter int PITCH_W = 5,
  parameter int DUR_W   = 13,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      wr_addr,
  input  logic [PITCH_W-1:0] wr_pitch,
  input  logic [DUR_W-1:0]   wr_dur,
  input  logic [AW-1:0]      rd_addr,
  output logic [PITCH_W-1:0] rd_pitch,
  output logic [DUR_W-1:0]   rd_dur
);

  typedef struct packed {
    logic [PITCH_W-1:0] pitch;
    logic [DUR_W-1:0]   dur;
  } entry_t;

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= '{pitch: wr_pitch, dur: wr_dur};
  end

  assign rd_pitch = mem[rd_addr].pitch;
  assign rd_dur   = mem[rd_addr].dur;

endmodule

// File: rtl/melody_sequencer.sv
// Table-driven note sequencer stepping on fs ticks; optional
// articulation gap via SEQ_ARTIC_GAP_EN. Ports: clk, reset (sync, low), bus.
module melody_sequencer
  import seq_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int PITCH_W = 5,
  parameter int DUR_W   = 13
`ifdef SEQ_ARTIC_GAP_EN
  , parameter int GAP_TICKS = 200
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  melody_sequencer_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);

  seq_state_e         state;
  logic [AW-1:0]      idx;
  logic [DUR_W-1:0]   ctr;
  logic [DUR_W-1:0]   dur_m1;
  logic [AW:0]        len;
  logic               loop;

  logic [AW-1:0]      nxt_idx;
  logic [PITCH_W-1:0] rd_pitch;
  logic [DUR_W-1:0]   rd_dur;
  logic [DUR_W-1:0]   ctr_inc;
  logic               last;
  logic               len_ok;

`ifdef SEQ_ARTIC_GAP_EN
  logic               gap_ok;
  logic [DUR_W-1:0]   gap_at;
`endif

  assign last    = ({1'b0, idx} == len - (AW+1)'(1));
  assign nxt_idx = (state == S_IDLE || last) ? '0 : idx + AW'(1);
  assign ctr_inc = ctr + DUR_W'(1);
  assign len_ok  = (bus.seq_len != '0) &&
                   (bus.seq_len <= (AW+1)'(DEPTH));

  // Read port always looks at the entry that would start next.
  seq_note_ram #(
    .DEPTH  (DEPTH),
    .PITCH_W(PITCH_W),
    .DUR_W  (DUR_W)
  ) u_ram (
    .clk     (clk),
    .we      (bus.wr_en && state == S_IDLE),
    .wr_addr (bus.wr_addr),
    .wr_pitch(bus.wr_pitch),
    .wr_dur  (bus.wr_dur),
    .rd_addr (nxt_idx),
    .rd_pitch(rd_pitch),
    .rd_dur  (rd_dur)
  );

  task automatic go_idle();
    state       <= S_IDLE;
    idx         <= '0;
    ctr         <= '0;
    bus.pitch_o <= '0;
    bus.note_on <= 1'b0;
    bus.note_idx <= '0;
    bus.busy    <= 1'b0;
  endtask

  // Entry duration is latched as dur-1 (dur==0 acts as 1).
  task automatic load_entry();
    state          <= S_PLAY;
    idx            <= nxt_idx;
    ctr            <= '0;
    dur_m1         <= (rd_dur == '0) ? '0 : rd_dur - DUR_W'(1);
    bus.pitch_o    <= rd_pitch;
    bus.note_on    <= (rd_pitch != '0);
    bus.note_start <= 1'b1;
    bus.note_idx   <= nxt_idx;
    bus.busy       <= 1'b1;
`ifdef SEQ_ARTIC_GAP_EN
    gap_ok         <= rd_dur > DUR_W'(GAP_TICKS);
    gap_at         <= rd_dur - DUR_W'(GAP_TICKS);
`endif
  endtask

  always_ff @(posedge clk) begin
    if (!reset) begin
      go_idle();
      dur_m1         <= '0;
      len            <= '0;
      loop           <= 1'b0;
      bus.note_start <= 1'b0;
      bus.done       <= 1'b0;
`ifdef SEQ_ARTIC_GAP_EN
      gap_ok         <= 1'b0;
      gap_at         <= '0;
`endif
    end else begin
      bus.note_start <= 1'b0;
      bus.done       <= 1'b0;
      if (bus.stop) begin
        go_idle();
      end else begin
        unique case (state)
          S_IDLE: begin
            if (bus.start && len_ok) begin
              len  <= bus.seq_len;
              loop <= bus.loop_en;
              load_entry();
            end
          end
          default: begin
            if (bus.tick) begin
              if (ctr >= dur_m1) begin
                if (last && !loop) begin
                  go_idle();
                  bus.done <= 1'b1;
                end else begin
                  load_entry();
                end
              end else begin
                ctr <= ctr_inc;
`ifdef SEQ_ARTIC_GAP_EN
                // Silence the tail GAP_TICKS of long entries.
                if (gap_ok && ctr_inc == gap_at) begin
                  state       <= S_GAP;
                  bus.pitch_o <= '0;
                  bus.note_on <= 1'b0;
                end
`endif
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed self-checking bench for melody_sequencer.
// Exercises reset, one-shot, loop, stop, dur=0, bad lengths, gap option.
module tb_melody_sequencer;
  import seq_pkg::*;

  localparam int DEPTH   = 32;
  localparam int PITCH_W = 5;
  localparam int DUR_W   = 13;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  melody_sequencer_if #(
    .DEPTH(DEPTH), .PITCH_W(PITCH_W), .DUR_W(DUR_W)
  ) bus ();

  melody_sequencer #(
    .DEPTH(DEPTH), .PITCH_W(PITCH_W), .DUR_W(DUR_W)
`ifdef SEQ_ARTIC_GAP_EN
    , .GAP_TICKS(2)
`endif
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int a, input int p, input int d);
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 5'(a);
    bus.wr_pitch = 5'(p);
    bus.wr_dur   = 13'(d);
    cyc();
    bus.wr_en = 1'b0;
  endtask

  task automatic tk();
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
  endtask

  task automatic go(input int l, input logic lp);
    bus.seq_len = 6'(l);
    bus.loop_en = lp;
    bus.start   = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic halt();
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
  endtask

  int ep;

  initial begin
    bus.tick = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_pitch = '0;
    bus.wr_dur = '0;
    bus.seq_len = '0;
    bus.loop_en = 1'b0;
    bus.start = 1'b0;
    bus.stop = 1'b0;

    cyc(3);
    chk("rst_pitch", 32'(bus.pitch_o), 0);
    chk("rst_note_on", 32'(bus.note_on), 0);
    chk("rst_note_start", 32'(bus.note_start), 0);
    chk("rst_idx", 32'(bus.note_idx), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    reset = 1'b1;
    bus.tick = 1'b0;
    cyc();

    wr(0, 18, 4);
    wr(1, 0, 2);
    wr(2, 13, 1);
    go(3, 1'b0);
    chk("os_start_pitch", 32'(bus.pitch_o), 18);
    chk("os_start_ns", 32'(bus.note_start), 1);
    chk("os_start_busy", 32'(bus.busy), 1);
    chk("os_start_on", 32'(bus.note_on), 1);
    cyc();
    chk("os_ns_clear", 32'(bus.note_start), 0);
    for (int t = 1; t <= 7; t++) begin
      tk();
      ep = (t < 4) ? 18 : (t < 6) ? 0 : (t < 7) ? 13 : 0;
      chk($sformatf("os_pitch_t%0d", t), 32'(bus.pitch_o), 32'(ep));
      chk($sformatf("os_ns_t%0d", t), 32'(bus.note_start),
          32'(t == 4 || t == 6));
      chk($sformatf("os_done_t%0d", t), 32'(bus.done), 32'(t == 7));
      if (t == 4) chk("os_rest_on", 32'(bus.note_on), 0);
      if (t == 6) chk("os_idx_t6", 32'(bus.note_idx), 2);
      cyc();
    end
    chk("os_done_pulse", 32'(bus.done), 0);
    chk("os_busy_end", 32'(bus.busy), 0);

    go(3, 1'b1);
    chk("lp_start_pitch", 32'(bus.pitch_o), 18);
    for (int t = 1; t <= 7; t++) begin
      tk();
      chk($sformatf("lp_done_t%0d", t), 32'(bus.done), 0);
    end
    chk("lp_wrap_idx", 32'(bus.note_idx), 0);
    chk("lp_wrap_pitch", 32'(bus.pitch_o), 18);
    chk("lp_wrap_ns", 32'(bus.note_start), 1);
    chk("lp_wrap_busy", 32'(bus.busy), 1);

    tk();
    bus.stop = 1'b1;
    bus.tick = 1'b1;
    bus.start = 1'b1;
    cyc();
    bus.stop = 1'b0;
    bus.tick = 1'b0;
    bus.start = 1'b0;
    chk("stop_busy", 32'(bus.busy), 0);
    chk("stop_pitch", 32'(bus.pitch_o), 0);
    chk("stop_on", 32'(bus.note_on), 0);
    chk("stop_done", 32'(bus.done), 0);
    cyc();
    chk("stop_done2", 32'(bus.done), 0);
    chk("stop_busy2", 32'(bus.busy), 0);

    wr(0, 7, 0);
    wr(1, 9, 3);
    go(2, 1'b0);
    chk("d0_pitch", 32'(bus.pitch_o), 7);
    tk();
    chk("d0_next_pitch", 32'(bus.pitch_o), 9);
    chk("d0_next_idx", 32'(bus.note_idx), 1);
    chk("d0_next_ns", 32'(bus.note_start), 1);
    halt();

    go(0, 1'b0);
    chk("len0_busy", 32'(bus.busy), 0);
    go(33, 1'b0);
    chk("len33_busy", 32'(bus.busy), 0);

    go(1, 1'b1);
    chk("l1_pitch", 32'(bus.pitch_o), 7);
    wr(0, 21, 5);
    tk();
    chk("l1_replay_pitch", 32'(bus.pitch_o), 7);
    chk("l1_replay_ns", 32'(bus.note_start), 1);
    chk("l1_replay_idx", 32'(bus.note_idx), 0);

    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_pitch", 32'(bus.pitch_o), 0);
    chk("mid_rst_done", 32'(bus.done), 0);

    go(1, 1'b0);
    chk("wr_busy_ignored", 32'(bus.pitch_o), 7);
    tk();
    chk("l1_os_done", 32'(bus.done), 1);

`ifdef SEQ_ARTIC_GAP_EN
    wr(0, 20, 6);
    go(1, 1'b0);
    chk("gap_start_pitch", 32'(bus.pitch_o), 20);
    for (int t = 1; t <= 6; t++) begin
      tk();
      chk($sformatf("gap_pitch_t%0d", t), 32'(bus.pitch_o),
          (t < 4) ? 32'd20 : 32'd0);
      chk($sformatf("gap_done_t%0d", t), 32'(bus.done), 32'(t == 6));
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
